ssid_request_arbiter: RTL and testbench

Shares the single SSID address port of the hit memories (HNM/HCM) between NREQ requesters, for example hit-fill logic and readout scanners. It performs round-robin arbitration under the memory's storageReady back-pressure. It drives SSID/newAddress the same way the address-counter does. It tags every issued address with its requester ID through a latency-matched pipeline, so memory read data can be routed back to the right requester.

---
 rtl/ssid_request_arbiter_if.sv | 30 +++
 rtl/ssid_request_arbiter.sv | 85 ++++++++
 tb/tb_ssid_request_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/ssid_request_arbiter_if.sv
// Handshake and memory-side bundle for the SSID request arbiter.
// The slave side is the arbiter; the master side drives requests.
interface ssid_request_arbiter_if #(
    parameter int SSIDBITS = 8,
    parameter int NREQ     = 4,
    parameter int IDBITS   = 2
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ*SSIDBITS-1:0] req_ssid;
    logic [NREQ-1:0]          req_ready;
    logic                     storageReady;
    logic [SSIDBITS-1:0]      SSID;
    logic                     newAddress;
    logic [IDBITS-1:0]        grant_id;
    logic                     resp_valid;
    logic [IDBITS-1:0]        resp_id;
    logic                     idle;

    modport master (
        output req_valid, req_ssid, storageReady,
        input  req_ready, SSID, newAddress, grant_id,
        input  resp_valid, resp_id, idle
    );

    modport slave (
        input  req_valid, req_ssid, storageReady,
        output req_ready, SSID, newAddress, grant_id,
        output resp_valid, resp_id, idle
    );
endinterface

// File: rtl/ssid_request_arbiter.sv
// Round-robin sharing of the hit-memory SSID port between requesters.
// Each issued address carries its requester ID down a latency-matched tag pipe.
module ssid_request_arbiter #(
    parameter int SSIDBITS    = 8,
    parameter int NREQ        = 4,
    parameter int IDBITS      = 2,
    parameter int MEM_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    ssid_request_arbiter_if.slave bus
);
    logic [IDBITS-1:0]   lastGrant;
    logic [IDBITS-1:0]   pick;
    logic [IDBITS-1:0]   cand;
    logic                found;
    logic                transfer;
    logic [NREQ-1:0]     ready;
    logic [SSIDBITS-1:0] selSsid;

    logic [SSIDBITS-1:0] ssidReg;
    logic [IDBITS-1:0]   grantReg;
    logic                strobe;

    logic [MEM_LATENCY-1:0] tagValid;
    logic [IDBITS-1:0]      tagId [MEM_LATENCY];

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        cand     = '0;
        ready    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDBITS'((int'(lastGrant) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        transfer = found && bus.storageReady && !reset;
        if (transfer) ready[pick] = 1'b1;
        selSsid  = bus.req_ssid[int'(pick) * SSIDBITS +: SSIDBITS];
    end

    // Address register, strobe and round-robin pointer; only a transfer moves them.
    always_ff @(posedge clock) begin
        if (reset) begin
            lastGrant <= IDBITS'(NREQ - 1);
            ssidReg   <= '1;
            grantReg  <= '0;
            strobe    <= 1'b0;
        end else begin
            strobe <= transfer;
            if (transfer) begin
                lastGrant <= pick;
                ssidReg   <= selSsid;
                grantReg  <= pick;
            end
        end
    end

    // Tag pipe: stage 0 samples the strobe and its ID every cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            tagValid <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) tagId[i] <= '0;
        end else begin
            tagValid[0] <= strobe;
            tagId[0]    <= grantReg;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tagValid[i] <= tagValid[i-1];
                tagId[i]    <= tagId[i-1];
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.SSID       = ssidReg;
    assign bus.newAddress = strobe;
    assign bus.grant_id   = grantReg;
    assign bus.resp_valid = tagValid[MEM_LATENCY-1];
    assign bus.resp_id    = tagId[MEM_LATENCY-1];
    assign bus.idle       = !strobe && !(|tagValid);
endmodule

// File: tb/tb_ssid_request_arbiter.sv
// Bench for ssid_request_arbiter: three instances (latency 2, 1, 8) share stimulus.
// Directed vectors push expectations; a negedge monitor pops and compares.
module tb_ssid_request_arbiter;
    localparam int LAT [3] = '{2, 1, 8};

    typedef struct { int cyc; logic [7:0] ssid; logic [1:0] id; } strobe_t;
    typedef struct { int cyc; logic [1:0] id; } resp_t;
    typedef struct { int cyc; logic [3:0] r; } ready_t;

    logic        clock;
    logic        reset;
    logic [3:0]  reqValid;
    logic [31:0] reqSsid;
    logic        storageReady;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit monOn = 0;
    bit done = 0;

    strobe_t strobeQ[$];
    resp_t   respQ[3][$];
    ready_t  readyQ[$];

    logic [3:0] rdy  [3];
    logic [7:0] ssidO[3];
    logic       newA [3];
    logic [1:0] gid  [3];
    logic       rv   [3];
    logic [1:0] rid  [3];
    logic       idl  [3];

    ssid_request_arbiter_if #(.SSIDBITS(8), .NREQ(4), .IDBITS(2)) bus2 ();
    ssid_request_arbiter_if #(.SSIDBITS(8), .NREQ(4), .IDBITS(2)) bus1 ();
    ssid_request_arbiter_if #(.SSIDBITS(8), .NREQ(4), .IDBITS(2)) bus8 ();

    ssid_request_arbiter #(.SSIDBITS(8), .NREQ(4), .IDBITS(2), .MEM_LATENCY(2))
        dut2 (.clock(clock), .reset(reset), .bus(bus2));
    ssid_request_arbiter #(.SSIDBITS(8), .NREQ(4), .IDBITS(2), .MEM_LATENCY(1))
        dut1 (.clock(clock), .reset(reset), .bus(bus1));
    ssid_request_arbiter #(.SSIDBITS(8), .NREQ(4), .IDBITS(2), .MEM_LATENCY(8))
        dut8 (.clock(clock), .reset(reset), .bus(bus8));

    assign bus2.req_valid = reqValid;
    assign bus2.req_ssid = reqSsid;
    assign bus2.storageReady = storageReady;
    assign bus1.req_valid = reqValid;
    assign bus1.req_ssid = reqSsid;
    assign bus1.storageReady = storageReady;
    assign bus8.req_valid = reqValid;
    assign bus8.req_ssid = reqSsid;
    assign bus8.storageReady = storageReady;

    assign rdy[0] = bus2.req_ready;
    assign rdy[1] = bus1.req_ready;
    assign rdy[2] = bus8.req_ready;
    assign ssidO[0] = bus2.SSID;
    assign ssidO[1] = bus1.SSID;
    assign ssidO[2] = bus8.SSID;
    assign newA[0] = bus2.newAddress;
    assign newA[1] = bus1.newAddress;
    assign newA[2] = bus8.newAddress;
    assign gid[0] = bus2.grant_id;
    assign gid[1] = bus1.grant_id;
    assign gid[2] = bus8.grant_id;
    assign rv[0] = bus2.resp_valid;
    assign rv[1] = bus1.resp_valid;
    assign rv[2] = bus8.resp_valid;
    assign rid[0] = bus2.resp_id;
    assign rid[1] = bus1.resp_id;
    assign rid[2] = bus8.resp_id;
    assign idl[0] = bus2.idle;
    assign idl[1] = bus1.idle;
    assign idl[2] = bus8.idle;

    initial clock = 0;
    always #5 clock = ~clock;

    // Free-running cycle index used to time-stamp expectations.
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s L=%0d cyc=%0d: got %0h, expected %0h",
                     name, LAT[d], cyc, act, exp);
        end
    endtask

    // One cycle of stimulus; expReady is the hand-computed one-hot grant.
    task automatic step(input logic rst, input logic [3:0] v,
                        input logic sr, input logic [3:0] expReady);
        int g;
        strobe_t s;
        resp_t r;
        ready_t q;
        reset = rst;
        reqValid = v;
        storageReady = sr;
        q.cyc = cyc;
        q.r = expReady;
        readyQ.push_back(q);
        if (expReady != 4'b0000) begin
            g = (expReady == 4'b0001) ? 0 :
                (expReady == 4'b0010) ? 1 :
                (expReady == 4'b0100) ? 2 : 3;
            s.cyc = cyc + 1;
            s.ssid = reqSsid[g*8 +: 8];
            s.id = 2'(g);
            strobeQ.push_back(s);
            for (int d = 0; d < 3; d++) begin
                r.cyc = cyc + 1 + LAT[d];
                r.id = 2'(g);
                respQ[d].push_back(r);
            end
        end
        @(posedge clock);
        #1;
    endtask

    // Stimulus: directed vectors.
    initial begin
        reset = 1;
        reqValid = 0;
        reqSsid = 0;
        storageReady = 0;
        @(posedge clock);
        #1;
        monOn = 1;
        step(1, 4'b1111, 1, 4'b0000);

        reqSsid = {8'h13, 8'h12, 8'h11, 8'h10};
        step(0, 4'b1111, 1, 4'b0001);
        step(0, 4'b1111, 1, 4'b0010);
        step(0, 4'b1111, 1, 4'b0100);
        step(0, 4'b1111, 1, 4'b1000);

        reqSsid = {8'h13, 8'h12, 8'h11, 8'h3C};
        step(0, 4'b0001, 1, 4'b0001);
        repeat (3) step(0, 4'b0000, 1, 4'b0000);

        reqSsid = {8'h33, 8'h22, 8'h11, 8'h30};
        step(0, 4'b0100, 1, 4'b0100);
        step(0, 4'b1101, 1, 4'b1000);
        step(0, 4'b1101, 1, 4'b0001);
        step(0, 4'b1101, 1, 4'b0100);

        repeat (3) step(0, 4'b0010, 0, 4'b0000);
        step(0, 4'b0010, 1, 4'b0010);
        step(0, 4'b1011, 0, 4'b0000);
        step(0, 4'b1011, 1, 4'b1000);
        step(0, 4'b1011, 1, 4'b0001);

        repeat (3) step(0, 4'b0100, 1, 4'b0100);
        repeat (10) step(0, 4'b0000, 1, 4'b0000);

        reqSsid = {8'h54, 8'h53, 8'h52, 8'h51};
        step(0, 4'b0001, 1, 4'b0001);
        step(0, 4'b0010, 1, 4'b0010);
        step(0, 4'b0000, 1, 4'b0000);
        step(1, 4'b1111, 1, 4'b0000);
        step(0, 4'b1111, 1, 4'b0001);

        step(0, 4'b1111, 1, 4'b0010);
        step(0, 4'b1111, 1, 4'b0100);
        step(0, 4'b1111, 1, 4'b1000);
        step(0, 4'b1111, 1, 4'b0001);
        step(0, 4'b1111, 1, 4'b0010);
        step(0, 4'b1111, 1, 4'b0100);
        repeat (10) step(0, 4'b0000, 1, 4'b0000);
        done = 1;
    end

    // Monitor: pops expectations due this cycle and compares every instance.
    initial begin
        logic [7:0] curSsid;
        logic [1:0] curGid;
        logic [7:0] expSsid;
        logic [1:0] expGid;
        bit hasE;
        bit hasR;
        bit busy;
        curSsid = 8'hFF;
        curGid = 2'd0;
        wait (monOn);
        while (!done) begin
            @(negedge clock);
            if (readyQ.size() > 0 && readyQ[0].cyc == cyc) begin
                for (int d = 0; d < 3; d++)
                    chk("req_ready", d, int'(rdy[d]), int'(readyQ[0].r));
                void'(readyQ.pop_front());
            end
            hasE = strobeQ.size() > 0 && strobeQ[0].cyc == cyc;
            expSsid = hasE ? strobeQ[0].ssid : curSsid;
            expGid = hasE ? strobeQ[0].id : curGid;
            for (int d = 0; d < 3; d++) begin
                busy = hasE;
                foreach (respQ[d][k])
                    if (respQ[d][k].cyc >= cyc && respQ[d][k].cyc < cyc + LAT[d])
                        busy = 1;
                chk("idle", d, int'(idl[d]), int'(!busy));
                chk("newAddress", d, int'(newA[d]), int'(hasE));
                chk("SSID", d, int'(ssidO[d]), int'(expSsid));
                chk("grant_id", d, int'(gid[d]), int'(expGid));
                hasR = respQ[d].size() > 0 && respQ[d][0].cyc == cyc;
                chk("resp_valid", d, int'(rv[d]), int'(hasR));
                if (hasR) begin
                    chk("resp_id", d, int'(rid[d]), int'(respQ[d][0].id));
                    void'(respQ[d].pop_front());
                end
            end
            if (hasE) begin
                curSsid = expSsid;
                curGid = expGid;
                void'(strobeQ.pop_front());
            end
            if (reset) begin
                curSsid = 8'hFF;
                curGid = 2'd0;
                for (int k = strobeQ.size() - 1; k >= 0; k--)
                    if (strobeQ[k].cyc > cyc) strobeQ.delete(k);
                for (int d = 0; d < 3; d++)
                    for (int k = respQ[d].size() - 1; k >= 0; k--)
                        if (respQ[d][k].cyc > cyc) respQ[d].delete(k);
            end
        end
        chk("strobes left", 0, strobeQ.size(), 0);
        for (int d = 0; d < 3; d++)
            chk("responses left", d, respQ[d].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
